attn_matmul_sequencer: RTL and testbench

//  Sequences one matrix product C[MxN] = A[MxK] * B[KxN] through the input, weight and result SRAM ports.
//  The weight SRAM holds B transposed, row j = column j of B.

---
 rtl/attn_matmul_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_attn_matmul_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/attn_matmul_sequencer.sv
// Sequences C = A * B through input, weight and result SRAM ports.
// The weight SRAM holds B transposed; one signed MAC per cycle and one result write per element.
module attn_matmul_sequencer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dut_valid,
    output logic              dut_ready,
    input  logic [DIM_W-1:0]  cfg_m,
    input  logic [DIM_W-1:0]  cfg_k,
    input  logic [DIM_W-1:0]  cfg_n,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic [ADDR_W-1:0] cfg_c_base,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rd_data,
    output logic [ADDR_W-1:0] wt_rd_addr,
    input  logic [DATA_W-1:0] wt_rd_data,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [DATA_W-1:0] res_wr_data,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [DIM_W-1:0]  DIM_ONE   = DIM_W'(1);
    localparam logic [DIM_W-1:0]  DIM_ZERO  = DIM_W'(0);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

    state_t              state_r, state_s;
    logic [DIM_W-1:0]    m_r, m_s, kdim_r, kdim_s, n_r, n_s;
    logic [DIM_W-1:0]    i_r, i_s, j_r, j_s, k_r, k_s;
    logic [ADDR_W-1:0]   b_base_r, b_base_s;
    logic [ADDR_W-1:0]   a_row_r, a_row_s, b_row_r, b_row_s, c_ptr_r, c_ptr_s;
    logic [ADDR_W-1:0]   in_addr_r, in_addr_s, wt_addr_r, wt_addr_s;
    logic                wr_en_r, wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0]   wr_data_r, wr_data_s;
    logic                ready_r, ready_s, done_r, done_s;
    logic [DATA_W-1:0]   acc_r, acc_s, prod_s, mac_s;
    logic                mac_vld_r, mac_vld_s, mac_first_r, mac_first_s;
    logic [ADDR_W-1:0]   k_step_s;

    assign dut_ready   = ready_r;
    assign done        = done_r;
    assign in_rd_addr  = in_addr_r;
    assign wt_rd_addr  = wt_addr_r;
    assign res_wr_en   = wr_en_r;
    assign res_wr_addr = wr_addr_r;
    assign res_wr_data = wr_data_r;

    // Next-state, running-offset address generation and MAC datapath
    always_comb begin
        state_s     = state_r;
        m_s         = m_r;
        kdim_s      = kdim_r;
        n_s         = n_r;
        i_s         = i_r;
        j_s         = j_r;
        k_s         = k_r;
        b_base_s    = b_base_r;
        a_row_s     = a_row_r;
        b_row_s     = b_row_r;
        c_ptr_s     = c_ptr_r;
        in_addr_s   = ADDR_ZERO;
        wt_addr_s   = ADDR_ZERO;
        wr_en_s     = 1'b0;
        wr_addr_s   = ADDR_ZERO;
        wr_data_s   = DATA_ZERO;
        mac_vld_s   = 1'b0;
        mac_first_s = 1'b0;
        k_step_s    = ADDR_W'(kdim_r);
        // Product truncated to DATA_W: low bits are identical for signed operands
        prod_s      = in_rd_data * wt_rd_data;
        if (mac_first_r) begin
            mac_s = prod_s;
        end else begin
            mac_s = acc_r + prod_s;
        end
        if (mac_vld_r) begin
            acc_s = mac_s;
        end else begin
            acc_s = acc_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (dut_valid && ready_r) begin
                    m_s      = cfg_m;
                    kdim_s   = cfg_k;
                    n_s      = cfg_n;
                    b_base_s = cfg_b_base;
                    a_row_s  = cfg_a_base;
                    b_row_s  = cfg_b_base;
                    c_ptr_s  = cfg_c_base;
                    i_s      = DIM_ZERO;
                    j_s      = DIM_ZERO;
                    k_s      = DIM_ZERO;
                    if ((cfg_m == DIM_ZERO) || (cfg_k == DIM_ZERO) || (cfg_n == DIM_ZERO)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s   = ST_READ;
                        in_addr_s = cfg_a_base;
                        wt_addr_s = cfg_b_base;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                mac_vld_s   = 1'b1;
                mac_first_s = (k_r == DIM_ZERO);
                if ((k_r + DIM_ONE) == kdim_r) begin
                    k_s     = DIM_ZERO;
                    state_s = ST_DRAIN;
                end else begin
                    k_s       = k_r + DIM_ONE;
                    in_addr_s = in_addr_r + ADDR_ONE;
                    wt_addr_s = wt_addr_r + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                wr_en_s   = 1'b1;
                wr_addr_s = c_ptr_r;
                wr_data_s = mac_s;
                state_s   = ST_WRITE;
            end
            ST_WRITE: begin
                // C is row-major, so the write pointer simply advances by one element
                c_ptr_s = c_ptr_r + ADDR_ONE;
                if ((j_r + DIM_ONE) == n_r) begin
                    j_s = DIM_ZERO;
                    if ((i_r + DIM_ONE) == m_r) begin
                        state_s = ST_DONE;
                    end else begin
                        i_s       = i_r + DIM_ONE;
                        a_row_s   = a_row_r + k_step_s;
                        b_row_s   = b_base_r;
                        in_addr_s = a_row_r + k_step_s;
                        wt_addr_s = b_base_r;
                        state_s   = ST_READ;
                    end
                end else begin
                    j_s       = j_r + DIM_ONE;
                    b_row_s   = b_row_r + k_step_s;
                    in_addr_s = a_row_r;
                    wt_addr_s = b_row_r + k_step_s;
                    state_s   = ST_READ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        ready_s = (state_s == ST_IDLE);
        done_s  = (state_s == ST_DONE);
    end

    // State, counters and registered outputs; reset is synchronous and active-high
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_r     <= ST_IDLE;
            m_r         <= DIM_ZERO;
            kdim_r      <= DIM_ZERO;
            n_r         <= DIM_ZERO;
            i_r         <= DIM_ZERO;
            j_r         <= DIM_ZERO;
            k_r         <= DIM_ZERO;
            b_base_r    <= ADDR_ZERO;
            a_row_r     <= ADDR_ZERO;
            b_row_r     <= ADDR_ZERO;
            c_ptr_r     <= ADDR_ZERO;
            in_addr_r   <= ADDR_ZERO;
            wt_addr_r   <= ADDR_ZERO;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= ADDR_ZERO;
            wr_data_r   <= DATA_ZERO;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            acc_r       <= DATA_ZERO;
            mac_vld_r   <= 1'b0;
            mac_first_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            m_r         <= m_s;
            kdim_r      <= kdim_s;
            n_r         <= n_s;
            i_r         <= i_s;
            j_r         <= j_s;
            k_r         <= k_s;
            b_base_r    <= b_base_s;
            a_row_r     <= a_row_s;
            b_row_r     <= b_row_s;
            c_ptr_r     <= c_ptr_s;
            in_addr_r   <= in_addr_s;
            wt_addr_r   <= wt_addr_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            ready_r     <= ready_s;
            done_r      <= done_s;
            acc_r       <= acc_s;
            mac_vld_r   <= mac_vld_s;
            mac_first_r <= mac_first_s;
        end
    end

endmodule

// File: tb/tb_attn_matmul_sequencer.sv
// Directed bench for attn_matmul_sequencer with 1-cycle-latency SRAM models.
// Cycle 0 is the accept cycle; outputs are sampled on the falling edge.
module tb_attn_matmul_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dut_valid;
    logic        dut_ready;
    logic [15:0] cfg_m, cfg_k, cfg_n;
    logic [11:0] cfg_a_base, cfg_b_base, cfg_c_base;
    logic [11:0] in_rd_addr, wt_rd_addr, res_wr_addr;
    logic [31:0] in_rd_data, wt_rd_data, res_wr_data;
    logic        res_wr_en;
    logic        done;

    logic [31:0] in_mem [0:4095];
    logic [31:0] wt_mem [0:4095];

    int checks = 0;
    int errors = 0;
    int cyc;
    int done_cyc, ready_cyc, done_cnt;
    int wr_cyc[$];
    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [11:0] rd_log [0:31];

    always #5 clk = ~clk;

    attn_matmul_sequencer dut (
        .clk(clk), .reset_n(reset_n), .dut_valid(dut_valid), .dut_ready(dut_ready),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
        .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
        .done(done)
    );

    // SRAM models with one cycle of read latency
    always_ff @(posedge clk) begin
        in_rd_data <= in_mem[in_rd_addr];
        wt_rd_data <= wt_mem[wt_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic log_cycle();
        if (cyc < 32) rd_log[cyc] = in_rd_addr;
        if (res_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(res_wr_addr);
            wr_data.push_back(res_wr_data);
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (done_cyc >= 0 && ready_cyc < 0 && dut_ready) ready_cyc = cyc;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        log_cycle();
    endtask

    task automatic run_to(input int last);
        while (cyc < last) tick();
    endtask

    // Called on a falling edge while the DUT is idle; that cycle becomes cycle 0
    task automatic start(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                         input logic [11:0] ab, input logic [11:0] bb, input logic [11:0] cb,
                         input bit hold);
        cfg_m = m; cfg_k = k; cfg_n = n;
        cfg_a_base = ab; cfg_b_base = bb; cfg_c_base = cb;
        dut_valid = 1'b1;
        cyc = 0;
        done_cyc = -1; ready_cyc = -1; done_cnt = 0;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 32; i++) rd_log[i] = 12'h000;
        log_cycle();
        tick();
        if (!hold) begin
            dut_valid = 1'b0;
            cfg_m = 16'($urandom); cfg_k = 16'($urandom); cfg_n = 16'($urandom);
            cfg_a_base = 12'($urandom); cfg_b_base = 12'($urandom); cfg_c_base = 12'($urandom);
        end
    endtask

    task automatic check_wr(input int idx, input int ecyc, input logic [11:0] eaddr,
                            input logic [31:0] edata);
        if (idx < wr_cyc.size()) begin
            check($sformatf("wr%0d_cycle", idx), 64'(wr_cyc[idx]), 64'(ecyc));
            check($sformatf("wr%0d_addr", idx), 64'(wr_addr[idx]), 64'(eaddr));
            check($sformatf("wr%0d_data", idx), 64'(wr_data[idx]), 64'(edata));
        end else begin
            check($sformatf("wr%0d_present", idx), 64'(wr_cyc.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            in_mem[i] = 32'h0;
            wt_mem[i] = 32'h0;
        end
        reset_n = 1'b1;
        dut_valid = 1'b0;
        cfg_m = 16'd0; cfg_k = 16'd0; cfg_n = 16'd0;
        cfg_a_base = 12'h0; cfg_b_base = 12'h0; cfg_c_base = 12'h0;
        cyc = 0; done_cyc = -1; ready_cyc = -1; done_cnt = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", 64'(dut_ready), 64'(1'b1));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_wr_en", 64'(res_wr_en), 64'(1'b0));
        check("rst_in_addr", 64'(in_rd_addr), 64'(12'h000));
        check("rst_wt_addr", 64'(wt_rd_addr), 64'(12'h000));
        check("rst_wr_addr", 64'(res_wr_addr), 64'(12'h000));
        check("rst_wr_data", 64'(res_wr_data), 64'(32'h0));
        reset_n = 1'b0;
        @(negedge clk);

        // 1x1x1: -3 * 7
        in_mem[10] = 32'hFFFF_FFFD;
        wt_mem[20] = 32'd7;
        start(16'd1, 16'd1, 16'd1, 12'd10, 12'd20, 12'd30, 1'b0);
        check("t1_in_addr_c1", 64'(in_rd_addr), 64'(12'd10));
        check("t1_wt_addr_c1", 64'(wt_rd_addr), 64'(12'd20));
        check("t1_ready_c1", 64'(dut_ready), 64'(1'b0));
        run_to(8);
        check("t1_wr_count", 64'(wr_cyc.size()), 64'(1));
        check_wr(0, 3, 12'd30, 32'hFFFF_FFEB);
        check("t1_done_cyc", 64'(done_cyc), 64'(4));
        check("t1_done_cnt", 64'(done_cnt), 64'(1));
        check("t1_ready_cyc", 64'(ready_cyc), 64'(5));

        // 2x2x2, all bases 0
        in_mem[0] = 32'd1; in_mem[1] = 32'd2; in_mem[2] = 32'd3; in_mem[3] = 32'd4;
        wt_mem[0] = 32'd5; wt_mem[1] = 32'd7; wt_mem[2] = 32'd6; wt_mem[3] = 32'd8;
        start(16'd2, 16'd2, 16'd2, 12'd0, 12'd0, 12'd0, 1'b0);
        run_to(21);
        check("t2_wr_count", 64'(wr_cyc.size()), 64'(4));
        check_wr(0, 4, 12'd0, 32'd19);
        check_wr(1, 8, 12'd1, 32'd22);
        check_wr(2, 12, 12'd2, 32'd43);
        check_wr(3, 16, 12'd3, 32'd50);
        check("t2_done_cyc", 64'(done_cyc), 64'(17));
        check("t2_ready_cyc", 64'(ready_cyc), 64'(18));

        // Accumulator wraps modulo 2^32
        in_mem[100] = 32'h7FFF_FFFF; in_mem[101] = 32'd1;
        wt_mem[200] = 32'd2;         wt_mem[201] = 32'd0;
        start(16'd1, 16'd2, 16'd1, 12'd100, 12'd200, 12'd50, 1'b0);
        run_to(8);
        check("t3_wr_count", 64'(wr_cyc.size()), 64'(1));
        check_wr(0, 4, 12'd50, 32'hFFFF_FFFE);
        check("t3_done_cyc", 64'(done_cyc), 64'(5));

        // Zero inner dimension
        start(16'd2, 16'd0, 16'd2, 12'd0, 12'd0, 12'd0, 1'b0);
        run_to(6);
        check("t4_wr_count", 64'(wr_cyc.size()), 64'(0));
        check("t4_done_cyc", 64'(done_cyc), 64'(1));
        check("t4_ready_cyc", 64'(ready_cyc), 64'(2));

        // Reset in cycle 6 of the 2x2x2 run
        start(16'd2, 16'd2, 16'd2, 12'd0, 12'd0, 12'd0, 1'b0);
        run_to(6);
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        check("t5_ready_after_rst", 64'(dut_ready), 64'(1'b1));
        check("t5_in_addr_after_rst", 64'(in_rd_addr), 64'(12'h000));
        run_to(24);
        check("t5_wr_count", 64'(wr_cyc.size()), 64'(1));
        check_wr(0, 4, 12'd0, 32'd19);
        check("t5_done_cnt", 64'(done_cnt), 64'(0));
        start(16'd2, 16'd2, 16'd2, 12'd0, 12'd0, 12'd0, 1'b0);
        run_to(21);
        check("t5b_wr_count", 64'(wr_cyc.size()), 64'(4));
        check_wr(3, 16, 12'd3, 32'd50);
        check("t5b_done_cyc", 64'(done_cyc), 64'(17));

        // dut_valid held high: exactly one product, then a second accept with new cfg
        in_mem[11] = 32'd5;
        wt_mem[21] = 32'd6;
        start(16'd1, 16'd1, 16'd1, 12'd10, 12'd20, 12'd30, 1'b1);
        run_to(4);
        cfg_a_base = 12'd11; cfg_b_base = 12'd21; cfg_c_base = 12'd31;
        run_to(5);
        check("t6_wr_count_first", 64'(wr_cyc.size()), 64'(1));
        check("t6_ready_c5", 64'(dut_ready), 64'(1'b1));
        run_to(6);
        dut_valid = 1'b0;
        run_to(14);
        check("t6_wr_count", 64'(wr_cyc.size()), 64'(2));
        check_wr(0, 3, 12'd30, 32'hFFFF_FFEB);
        check_wr(1, 8, 12'd31, 32'd30);
        check("t6_done_cnt", 64'(done_cnt), 64'(2));

        // Read address wraps past the top of the address space
        in_mem[12'hFFF] = 32'd3;
        wt_mem[300] = 32'd4; wt_mem[301] = 32'd5;
        start(16'd1, 16'd2, 16'd1, 12'hFFF, 12'd300, 12'd60, 1'b0);
        run_to(8);
        check("t7_rd_c1", 64'(rd_log[1]), 64'(12'hFFF));
        check("t7_rd_c2", 64'(rd_log[2]), 64'(12'h000));
        check_wr(0, 4, 12'd60, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
